// File: rtl/flash_fetch_sequencer.sv
// flash_fetch_sequencer
// Debounces the up/down board buttons, steps the 24-bit flash read address,
// drives the flashNavigator read enable, captures the returned byte and hands
// it to the UART transmitter. All control lives in one single-clock FSM.
//
// Handshakes:
//   flash side - flash_enable is held high from REQUEST through WAIT_DATA; a
//                byte is accepted only on a low-to-high transition of the
//                flash_data_ready level (previous sample low, current high).
//   uart side  - tx_start is a one-cycle strobe issued only while tx_busy is
//                low; the UART acknowledges by raising tx_busy within
//                TX_ACK_CYCLES cycles and drops it when the byte is out.
module flash_fetch_sequencer #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd270000,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd20000000,
   parameter logic [23:0] START_ADDR      = 24'd1,
   parameter logic [23:0] ADDR_MIN        = 24'd0,
   parameter logic [23:0] ADDR_MAX        = 24'hFFFFFF,
   parameter logic [2:0]  TX_ACK_CYCLES   = 3'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up_n,
   input  logic        btn_down_n,
   output logic [23:0] flash_addr,
   output logic        flash_enable,
   input  logic [7:0]  flash_data,
   input  logic        flash_data_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        fetch_error,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_BOOT      = 3'd0,
      S_IDLE      = 3'd1,
      S_REQUEST   = 3'd2,
      S_WAIT_DATA = 3'd3,
      S_SEND      = 3'd4,
      S_WAIT_TX   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_UP   = 2'd1,
      EV_DOWN = 2'd2
   } event_t;

   // Button synchronizers (reset to the released, high level)
   logic        r_up_meta, r_up_sync, r_dn_meta, r_dn_sync;
   // Debounce counters and accepted levels (active low, 1 = released)
   logic [19:0] r_up_cnt, r_dn_cnt;
   logic        r_up_db, r_dn_db;
   // Single-entry pending button event
   event_t      r_pending;
   // FSM and registered outputs
   state_t      r_state;
   logic [23:0] r_flash_addr;
   logic        r_flash_enable;
   logic [7:0]  r_tx_data;
   logic        r_tx_start;
   logic        r_fetch_error;
   logic [31:0] r_timeout_cnt;
   logic [2:0]  r_ack_cnt;
   logic        r_ack_seen;
   logic        r_ready_prev;

   logic        w_up_accept, w_dn_accept;
   logic        w_up_press, w_dn_press;
   event_t      w_event;
   logic        w_consume;
   logic        w_ready_rise;

   // Two-flop synchronizers for the asynchronous buttons
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_up_meta <= 1'b1;
         r_up_sync <= 1'b1;
         r_dn_meta <= 1'b1;
         r_dn_sync <= 1'b1;
      end else begin
         r_up_meta <= btn_up_n;
         r_up_sync <= r_up_meta;
         r_dn_meta <= btn_down_n;
         r_dn_sync <= r_dn_meta;
      end
   end

   // A new level is accepted once it has differed from the accepted level for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
   assign w_up_accept = (r_up_sync != r_up_db) && (r_up_cnt == DEBOUNCE_CYCLES - 20'd1);
   assign w_dn_accept = (r_dn_sync != r_dn_db) && (r_dn_cnt == DEBOUNCE_CYCLES - 20'd1);
   assign w_up_press  = w_up_accept && !r_up_sync;
   assign w_dn_press  = w_dn_accept && !r_dn_sync;

   // Up-button debounce counter and accepted level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_up_cnt <= '0;
         r_up_db  <= 1'b1;
      end else if (r_up_sync == r_up_db) begin
         r_up_cnt <= '0;
      end else if (w_up_accept) begin
         r_up_cnt <= '0;
         r_up_db  <= r_up_sync;
      end else begin
         r_up_cnt <= r_up_cnt + 20'd1;
      end
   end

   // Down-button debounce counter and accepted level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dn_cnt <= '0;
         r_dn_db  <= 1'b1;
      end else if (r_dn_sync == r_dn_db) begin
         r_dn_cnt <= '0;
      end else if (w_dn_accept) begin
         r_dn_cnt <= '0;
         r_dn_db  <= r_dn_sync;
      end else begin
         r_dn_cnt <= r_dn_cnt + 20'd1;
      end
   end

   // Simultaneous up and down presses cancel each other
   always_comb begin
      w_event = EV_NONE;
      if (w_up_press && !w_dn_press) begin
         w_event = EV_UP;
      end else if (w_dn_press && !w_up_press) begin
         w_event = EV_DOWN;
      end
   end

   assign w_consume    = (r_state == S_IDLE) && (r_pending != EV_NONE);
   assign w_ready_rise = flash_data_ready && !r_ready_prev;

   // Pending slot: latest event wins; an event arriving as the slot is
   // consumed becomes the next pending entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= EV_NONE;
      end else if (w_event != EV_NONE) begin
         r_pending <= w_event;
      end else if (w_consume) begin
         r_pending <= EV_NONE;
      end
   end

   // Fetch sequencing FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_BOOT;
         r_flash_addr   <= START_ADDR;
         r_flash_enable <= 1'b0;
         r_tx_data      <= '0;
         r_tx_start     <= 1'b0;
         r_fetch_error  <= 1'b0;
         r_timeout_cnt  <= '0;
         r_ack_cnt      <= '0;
         r_ack_seen     <= 1'b0;
         r_ready_prev   <= 1'b0;
      end else begin
         r_ready_prev <= flash_data_ready;
         r_tx_start   <= 1'b0;
         case (r_state)
            S_BOOT: begin
               r_state <= S_REQUEST;
            end
            S_IDLE: begin
               r_flash_enable <= 1'b0;
               // Address is updated on the same edge as the move to REQUEST so
               // it is already stable when flash_enable rises.
               if (r_pending == EV_UP) begin
                  if (r_flash_addr < ADDR_MAX) begin
                     r_flash_addr <= r_flash_addr + 24'd1;
                  end
                  r_state <= S_REQUEST;
               end else if (r_pending == EV_DOWN) begin
                  if (r_flash_addr > ADDR_MIN) begin
                     r_flash_addr <= r_flash_addr - 24'd1;
                  end
                  r_state <= S_REQUEST;
               end
            end
            S_REQUEST: begin
               r_flash_enable <= 1'b1;
               r_timeout_cnt  <= '0;
               r_state        <= S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
               r_timeout_cnt <= r_timeout_cnt + 32'd1;
               // A data edge on the timeout cycle still counts as success
               if (w_ready_rise) begin
                  r_tx_data      <= flash_data;
                  r_flash_enable <= 1'b0;
                  r_fetch_error  <= 1'b0;
                  r_state        <= S_SEND;
               end else if (r_timeout_cnt == TIMEOUT_CYCLES - 32'd1) begin
                  r_fetch_error  <= 1'b1;
                  r_flash_enable <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            S_SEND: begin
               if (!tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_ack_cnt  <= '0;
                  r_ack_seen <= 1'b0;
                  r_state    <= S_WAIT_TX;
               end
            end
            S_WAIT_TX: begin
               // The UART gets a bounded window to acknowledge; once busy is
               // seen there is no limit on how long the byte takes to go out.
               if (!r_ack_seen) begin
                  if (tx_busy) begin
                     r_ack_seen <= 1'b1;
                  end else if (r_ack_cnt == TX_ACK_CYCLES - 3'd1) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_ack_cnt <= r_ack_cnt + 3'd1;
                  end
               end else if (!tx_busy) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_flash_enable <= 1'b0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

   assign flash_addr   = r_flash_addr;
   assign flash_enable = r_flash_enable;
   assign tx_data      = r_tx_data;
   assign tx_start     = r_tx_start;
   assign fetch_error  = r_fetch_error;
   assign state_dbg    = r_state;

endmodule

// File: tb/tb_flash_fetch_sequencer.sv
// Bench for flash_fetch_sequencer: directed button, flash and UART scenarios
// checked cycle by cycle against a behavioural model, plus literal checks.
module tb_flash_fetch_sequencer;

   localparam int DB = 8;      // debounce cycles used in this bench
   localparam int TO = 100;    // fetch timeout cycles
   localparam int ACK = 4;     // UART acknowledge window

   localparam int PH_BOOT = 0;
   localparam int PH_IDLE = 1;
   localparam int PH_REQ  = 2;
   localparam int PH_WAIT = 3;
   localparam int PH_SEND = 4;
   localparam int PH_WTX  = 5;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_up_n, btn_down_n;
   logic [7:0]  flash_data;
   logic        flash_data_ready;
   logic        tx_busy;
   logic [23:0] flash_addr, hi_addr;
   logic        flash_enable, hi_en;
   logic [7:0]  tx_data, hi_txd;
   logic        tx_start, hi_start;
   logic        fetch_error, hi_err;
   logic [2:0]  state_dbg, hi_state;

   always #5 clk = ~clk;

   flash_fetch_sequencer #(
      .DEBOUNCE_CYCLES(20'd8), .TIMEOUT_CYCLES(32'd100), .START_ADDR(24'd1),
      .ADDR_MIN(24'd0), .ADDR_MAX(24'hFFFFFF), .TX_ACK_CYCLES(3'd4)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .flash_addr(flash_addr), .flash_enable(flash_enable), .flash_data(flash_data),
      .flash_data_ready(flash_data_ready), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .fetch_error(fetch_error), .state_dbg(state_dbg)
   );

   // Second instance starting next to the top of the address space
   flash_fetch_sequencer #(
      .DEBOUNCE_CYCLES(20'd8), .TIMEOUT_CYCLES(32'd100), .START_ADDR(24'hFFFFFE),
      .ADDR_MIN(24'd0), .ADDR_MAX(24'hFFFFFF), .TX_ACK_CYCLES(3'd4)
   ) u_dut_hi (
      .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .flash_addr(hi_addr), .flash_enable(hi_en), .flash_data(flash_data),
      .flash_data_ready(flash_data_ready), .tx_data(hi_txd), .tx_start(hi_start),
      .tx_busy(tx_busy), .fetch_error(hi_err), .state_dbg(hi_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];
   int          n_starts = 0;
   logic        prev_en = 1'b0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- flash and UART responders ----------------
   int       resp_delay = 30;
   logic [7:0] resp_byte = 8'hA5;
   int       en_cnt = 0;
   int       busy_len = 4;
   bit       busy_force = 1'b0;
   bit       uart_mute = 1'b0;
   int       u_cnt = 0;

   always @(negedge clk) begin
      if (flash_enable) begin
         en_cnt++;
         if (resp_delay != 0 && en_cnt == resp_delay) begin
            flash_data_ready = 1'b1;
            flash_data = resp_byte;
         end
      end else begin
         en_cnt = 0;
         flash_data_ready = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (tx_start && !uart_mute) u_cnt = 1;
      else if (u_cnt != 0) u_cnt++;
      if (u_cnt >= 3 + busy_len) u_cnt = 0;
      tx_busy = busy_force || (u_cnt >= 3);
   end

   // ---------------- behavioural model ----------------
   logic [23:0]   m_addr, m_addr_hi;
   logic          m_en, m_start, m_err;
   logic [7:0]    m_txd;
   int            m_ph = PH_BOOT;
   int            m_pend = 0;    // 0 none, 1 up, 2 down
   int            m_wait, m_ackw;
   bit            m_seen, m_rdy_prev, m_valid = 1'b0;
   logic [DB+1:0] up_h, dn_h;    // bit k = raw level sampled k edges ago
   logic          up_db, dn_db;

   always @(posedge clk) begin
      bit ev_up, ev_dn, took;
      int new_ev;
      if (!rst_n) begin
         m_addr = 24'd1; m_addr_hi = 24'hFFFFFE;
         m_en = 1'b0; m_txd = 8'd0; m_start = 1'b0; m_err = 1'b0;
         m_pend = 0; m_ph = PH_BOOT; m_wait = 0; m_ackw = 0; m_seen = 1'b0;
         m_rdy_prev = 1'b0; up_h = '1; dn_h = '1; up_db = 1'b1; dn_db = 1'b1;
         m_valid = 1'b1;
      end else begin
         // The debouncer sees the raw level two edges late; it accepts a level
         // that has differed from the held one for DB edges in a row.
         up_h = {up_h[DB:0], btn_up_n};
         dn_h = {dn_h[DB:0], btn_down_n};
         ev_up = 1'b0; ev_dn = 1'b0;
         if (up_h[DB+1:2] == {DB{~up_db}}) begin up_db = ~up_db; ev_up = !up_db; end
         if (dn_h[DB+1:2] == {DB{~dn_db}}) begin dn_db = ~dn_db; ev_dn = !dn_db; end
         new_ev = (ev_up && !ev_dn) ? 1 : ((ev_dn && !ev_up) ? 2 : 0);
         took = 1'b0;
         m_start = 1'b0;
         case (m_ph)
            PH_BOOT: m_ph = PH_REQ;
            PH_IDLE: begin
               m_en = 1'b0;
               if (m_pend == 1) begin
                  if (m_addr != 24'hFFFFFF) m_addr = m_addr + 1;
                  if (m_addr_hi != 24'hFFFFFF) m_addr_hi = m_addr_hi + 1;
               end else if (m_pend == 2) begin
                  if (m_addr != 0) m_addr = m_addr - 1;
                  if (m_addr_hi != 0) m_addr_hi = m_addr_hi - 1;
               end
               if (m_pend != 0) begin took = 1'b1; m_ph = PH_REQ; end
            end
            PH_REQ: begin m_en = 1'b1; m_wait = 0; m_ph = PH_WAIT; end
            PH_WAIT: begin
               m_wait++;
               if (flash_data_ready && !m_rdy_prev) begin
                  m_txd = flash_data; m_en = 1'b0; m_err = 1'b0; m_ph = PH_SEND;
               end else if (m_wait == TO) begin
                  m_err = 1'b1; m_en = 1'b0; m_ph = PH_IDLE;
               end
            end
            PH_SEND: if (!tx_busy) begin
               m_start = 1'b1; m_ackw = 0; m_seen = 1'b0; m_ph = PH_WTX;
            end
            PH_WTX: begin
               if (!m_seen) begin
                  if (tx_busy) m_seen = 1'b1;
                  else begin m_ackw++; if (m_ackw == ACK) m_ph = PH_IDLE; end
               end else if (!tx_busy) m_ph = PH_IDLE;
            end
            default: m_ph = PH_IDLE;
         endcase
         if (took) m_pend = new_ev;
         else if (new_ev != 0) m_pend = new_ev;
         m_rdy_prev = flash_data_ready;
      end
   end

   // Per-cycle comparison of both instances against the model, plus fetch log
   always @(negedge clk) begin
      logic [2:0] exp_st;
      exp_st = 3'(m_ph);
      if (m_valid) begin
         check("cycle",
               {52'd0, flash_addr, hi_addr, flash_enable, hi_en, tx_data, hi_txd,
                tx_start, hi_start, fetch_error, hi_err, state_dbg, hi_state},
               {52'd0, m_addr, m_addr_hi, m_en, m_en, m_txd, m_txd,
                m_start, m_start, m_err, m_err, exp_st, exp_st});
      end
      if (flash_enable && !prev_en) got_q.push_back(flash_addr);
      if (tx_start) n_starts++;
      prev_en = flash_enable;
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit up, input bit dn, input int len);
      @(negedge clk);
      btn_up_n = ~up; btn_down_n = ~dn;
      repeat (len) @(negedge clk);
      btn_up_n = 1'b1; btn_down_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(m_ph == PH_IDLE && m_pend == 0) && n < 3000) begin
         @(negedge clk); n++;
      end
      if (n >= 3000) begin
         n_checks++; n_fail++;
         $display("FAIL %s idle_wait expired after %0d cycles", name, n);
      end
      idle(14);
   endtask

   task automatic check_fetches(input string name, input int exp_starts);
      check({name, "_nfetch"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({name, "_addr"}, 128'(got_q[i]), 128'(exp_q[i]));
      check({name, "_nstart"}, 128'(n_starts), 128'(exp_starts));
      exp_q.delete(); got_q.delete(); n_starts = 0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      rst_n = 1'b0; btn_up_n = 1'b1; btn_down_n = 1'b1;
      flash_data = 8'd0; flash_data_ready = 1'b0; tx_busy = 1'b0;
      idle(3);
      check("rst_addr", 128'(flash_addr), 128'(24'd1));
      check("rst_en", 128'(flash_enable), 128'(0));
      check("rst_state", 128'(state_dbg), 128'(0));
      check("rst_txd", 128'(tx_data), 128'(0));
      rst_n = 1'b1;

      // 1: automatic boot fetch of address 1, byte A5 after 30 enable cycles
      wait_idle("boot");
      exp_q.push_back(24'd1);
      check_fetches("boot", 1);
      check("boot_txd", 128'(tx_data), 128'(8'hA5));
      check("boot_state", 128'(state_dbg), 128'(1));

      // 2: three short glitches then a long hold -> one fetch at 2; UART
      // never acknowledges so WAIT_TX leaves on its own window
      uart_mute = 1'b1; resp_byte = 8'h3C;
      press(1, 0, 3); idle(3);
      press(1, 0, 5); idle(3);
      press(1, 0, 2); idle(3);
      press(1, 0, DB + 5);
      wait_idle("glitch");
      uart_mute = 1'b0;
      exp_q.push_back(24'd2);
      check_fetches("glitch", 1);
      check("glitch_txd", 128'(tx_data), 128'(8'h3C));
      check("hi_sat_up1", 128'(hi_addr), 128'(24'hFFFFFF));

      // 3: saturation at both ends
      press(1, 0, 12); wait_idle("up2");
      check("hi_sat_up2", 128'(hi_addr), 128'(24'hFFFFFF));
      for (int i = 0; i < 4; i++) begin
         press(0, 1, 12); wait_idle("down");
      end
      check("lo_sat", 128'(flash_addr), 128'(24'd0));
      exp_q.push_back(24'd3); exp_q.push_back(24'd2); exp_q.push_back(24'd1);
      exp_q.push_back(24'd0); exp_q.push_back(24'd0);
      check_fetches("sat", 5);

      // 4: timeout, then a successful retry clears fetch_error
      resp_delay = 0;
      press(1, 0, 12); wait_idle("timeout");
      check("to_err", 128'(fetch_error), 128'(1));
      check("to_en", 128'(flash_enable), 128'(0));
      resp_delay = 10; resp_byte = 8'h5A;
      press(0, 1, 12); wait_idle("retry");
      check("retry_err", 128'(fetch_error), 128'(0));
      check("retry_txd", 128'(tx_data), 128'(8'h5A));
      exp_q.push_back(24'd1); exp_q.push_back(24'd0);
      check_fetches("timeout", 1);

      // 5: up during WAIT_DATA, down during a 50-cycle busy SEND -> latest wins
      resp_delay = 40; resp_byte = 8'h77;
      press(1, 0, 12);
      n = 0;
      while (!flash_enable && n < 200) begin @(negedge clk); n++; end
      check("ovr_en_seen", 128'(flash_enable), 128'(1));
      busy_force = 1'b1;
      press(1, 0, 12);
      n = 0;
      while (m_ph != PH_SEND && n < 200) begin @(negedge clk); n++; end
      check("ovr_in_send", 128'(state_dbg), 128'(4));
      press(0, 1, 12);
      idle(38);
      check("ovr_hold_state", 128'(state_dbg), 128'(4));
      busy_force = 1'b0;
      wait_idle("override");
      exp_q.push_back(24'd1); exp_q.push_back(24'd0);
      check_fetches("override", 2);
      check("hi_after_ovr", 128'(hi_addr), 128'(24'hFFFFFB));

      // 6: both buttons pressed together -> no fetch
      press(1, 1, 12);
      idle(40);
      check_fetches("both", 0);
      check("both_state", 128'(state_dbg), 128'(1));

      // 7: reset while waiting for the UART, then the BOOT fetch of 1
      resp_delay = 5; resp_byte = 8'hC3; busy_len = 20;
      press(1, 0, 12);
      n = 0;
      while (!(m_ph == PH_WTX && tx_busy) && n < 300) begin @(negedge clk); n++; end
      check("rst_in_wtx", 128'(state_dbg), 128'(5));
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_addr", 128'(flash_addr), 128'(24'd1));
      check("mid_rst_hi", 128'(hi_addr), 128'(24'hFFFFFE));
      check("mid_rst_en", 128'(flash_enable), 128'(0));
      check("mid_rst_txd", 128'(tx_data), 128'(0));
      check("mid_rst_start", 128'(tx_start), 128'(0));
      check("mid_rst_err", 128'(fetch_error), 128'(0));
      check("mid_rst_state", 128'(state_dbg), 128'(0));
      rst_n = 1'b1;
      wait_idle("reboot");
      exp_q.push_back(24'd1); exp_q.push_back(24'd1);
      check_fetches("reboot", 2);
      check("reboot_txd", 128'(tx_data), 128'(8'hC3));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
